// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory channel, valid/ready request plus in-order response without backpressure.
interface if_fetch_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    modport master(output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
    modport slave(input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage owning the PC, one outstanding imem fetch, registered IF_ID outputs with NOP bubbles.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   reset,
    if_fetch_unit_if.master        imem,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    input  logic                   stall,
    output logic [31:0]            instr_if,
    output logic [31:0]            pc_if,
    output logic [31:0]            pc_plus4_if,
    output logic                   valid_if
);
    typedef enum logic [1:0] {REQ, WAIT, FULL, DROP} state_t;
    state_t      state, state_d;
    logic [31:0] pc_q, pc_d, fpc_q, fpc_d, buf_q, buf_d, ld_data, fpc4;
    logic        ld;
    assign fpc4           = fpc_q + 32'd4;
    assign imem.req_valid = state == REQ && !redirect_valid;
    assign imem.req_addr  = pc_q;
    always_comb begin
        state_d = state;
        pc_d    = pc_q;
        fpc_d   = fpc_q;
        buf_d   = buf_q;
        ld      = 1'b0;
        ld_data = buf_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            // a fetch still in flight must be swallowed before the next request
            state_d = (state == WAIT || state == DROP) && !imem.rsp_valid ? DROP : REQ;
        end else begin
            case (state)
                REQ: if (imem.req_ready) begin
                    fpc_d   = pc_q;
                    state_d = WAIT;
                end
                WAIT: if (imem.rsp_valid) begin
                    pc_d    = fpc4;
                    buf_d   = imem.rsp_data;
                    ld_data = imem.rsp_data;
                    ld      = !stall;
                    state_d = stall ? FULL : REQ;
                end
                FULL: if (!stall) begin
                    ld      = 1'b1;
                    state_d = REQ;
                end
                default: if (imem.rsp_valid) state_d = REQ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= REQ;
            pc_q        <= RESET_PC;
            fpc_q       <= '0;
            buf_q       <= '0;
            instr_if    <= NOP_INSTR;
            pc_if       <= '0;
            pc_plus4_if <= '0;
            valid_if    <= 1'b0;
        end else begin
            state <= state_d;
            pc_q  <= pc_d;
            fpc_q <= fpc_d;
            buf_q <= buf_d;
            if (ld) begin
                instr_if    <= ld_data;
                pc_if       <= fpc_q;
                pc_plus4_if <= fpc4;
                valid_if    <= 1'b1;
            end else if (redirect_valid || !stall) begin
                instr_if <= NOP_INSTR;
                valid_if <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed vector table, multi-cycle corner sequences and a randomized fetch-stream scoreboard.
module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0;
    logic        reset = 1'b1, reset2 = 1'b1, redirect_valid = 1'b0, stall = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr_if, pc_if, pc_plus4_if, instr2, pc2, pc42;
    logic        valid_if, valid2;
    logic        pre_req, pre_req2;
    logic [31:0] pre_addr, pre_addr2;
    int          checks = 0, failures = 0;

    if_fetch_unit_if imem();
    if_fetch_unit_if imem2();

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .imem(imem), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stall(stall), .instr_if(instr_if), .pc_if(pc_if),
        .pc_plus4_if(pc_plus4_if), .valid_if(valid_if)
    );
    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset2), .imem(imem2), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stall(stall), .instr_if(instr2), .pc_if(pc2),
        .pc_plus4_if(pc42), .valid_if(valid2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] md(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic rdy, input logic rsp, input logic [31:0] data,
                        input logic st, input logic rv, input logic [31:0] rp);
        reset = r; imem.req_ready = rdy; imem.rsp_valid = rsp; imem.rsp_data = data;
        stall = st; redirect_valid = rv; redirect_pc = rp;
        @(negedge clk);
        pre_req = imem.req_valid; pre_addr = imem.req_addr;
        pre_req2 = imem2.req_valid; pre_addr2 = imem2.req_addr;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic r, rdy, rsp; logic [31:0] data; logic st;
        logic e_req; logic [31:0] e_addr; logic e_v; logic [31:0] e_pc, e_p4, e_ins;
    } vec_t;

    function automatic vec_t v(input logic r, input logic rdy, input logic rsp, input logic [31:0] data,
                               input logic st, input logic e_req, input logic [31:0] e_addr,
                               input logic e_v, input logic [31:0] e_pc, input logic [31:0] e_p4,
                               input logic [31:0] e_ins);
        return '{r, rdy, rsp, data, st, e_req, e_addr, e_v, e_pc, e_p4, e_ins};
    endfunction

    vec_t tbl[12];

    initial begin
        imem2.req_ready = 1'b0; imem2.rsp_valid = 1'b0; imem2.rsp_data = '0;
        tbl[0]  = v(1, 0, 0, 0,       0, 0, 0,  0, 0,  0,  NOP);
        tbl[1]  = v(0, 1, 0, 0,       0, 1, 0,  0, 0,  0,  NOP);
        tbl[2]  = v(0, 0, 1, md(0),   0, 0, 0,  1, 0,  4,  md(0));
        tbl[3]  = v(0, 1, 0, 0,       0, 1, 4,  0, 0,  4,  NOP);
        tbl[4]  = v(0, 0, 0, 0,       1, 0, 0,  0, 0,  4,  NOP);
        tbl[5]  = v(0, 0, 1, md(4),   1, 0, 0,  0, 0,  4,  NOP);
        tbl[6]  = v(0, 0, 0, 0,       1, 0, 0,  0, 0,  4,  NOP);
        tbl[7]  = v(0, 0, 0, 0,       0, 0, 0,  1, 4,  8,  md(4));
        tbl[8]  = v(0, 1, 0, 0,       0, 1, 8,  0, 4,  8,  NOP);
        tbl[9]  = v(0, 0, 1, md(8),   0, 0, 0,  1, 8,  12, md(8));
        tbl[10] = v(0, 1, 0, 0,       1, 1, 12, 1, 8,  12, md(8));
        tbl[11] = v(0, 0, 1, md(12),  0, 0, 0,  1, 12, 16, md(12));
        foreach (tbl[i]) begin
            tick(tbl[i].r, tbl[i].rdy, tbl[i].rsp, tbl[i].data, tbl[i].st, 1'b0, '0);
            if (!tbl[i].r) chk($sformatf("vec%0d_req_valid", i), pre_req, tbl[i].e_req);
            if (tbl[i].e_req) chk($sformatf("vec%0d_req_addr", i), pre_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_valid_if", i), valid_if, tbl[i].e_v);
            chk($sformatf("vec%0d_pc_if", i), pc_if, tbl[i].e_pc);
            chk($sformatf("vec%0d_pc_plus4_if", i), pc_plus4_if, tbl[i].e_p4);
            chk($sformatf("vec%0d_instr_if", i), instr_if, tbl[i].e_ins);
        end

        // redirect while waiting on a slow response
        tick(0, 1, 0, 0, 0, 0, 0);             chk("t3_req_addr", pre_addr, 32'h10);
        tick(0, 0, 0, 0, 0, 1, 32'h103);       chk("t3_flush_valid", valid_if, 0); chk("t3_flush_instr", instr_if, NOP);
        tick(0, 1, 0, 0, 0, 0, 0);             chk("t3_drop_no_req", pre_req, 0);
        tick(0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0); chk("t3_stale_discard", valid_if, 0); chk("t3_drop_no_req2", pre_req, 0);
        tick(0, 1, 0, 0, 0, 0, 0);             chk("t3_target_req", pre_req, 1); chk("t3_target_addr", pre_addr, 32'h100);
        tick(0, 0, 1, md(32'h100), 0, 0, 0);   chk("t3_valid", valid_if, 1); chk("t3_pc", pc_if, 32'h100); chk("t3_instr", instr_if, md(32'h100));
        // redirect coinciding with the response
        tick(0, 1, 0, 0, 0, 0, 0);             chk("t4_req_addr", pre_addr, 32'h104);
        tick(0, 0, 1, 32'hBAD0_0BAD, 0, 1, 32'h200); chk("t4_discard", valid_if, 0); chk("t4_instr", instr_if, NOP);
        tick(0, 1, 0, 0, 0, 0, 0);             chk("t4_target_req", pre_req, 1); chk("t4_target_addr", pre_addr, 32'h200);
        tick(0, 0, 1, md(32'h200), 0, 0, 0);   chk("t4_valid", valid_if, 1); chk("t4_pc", pc_if, 32'h200);
        // memory not ready, redirect in the middle
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 0, i == 2, 32'h300);
            if (i == 2) chk("t5_req_low_redirect", pre_req, 0);
            else begin
                chk("t5_req_held", pre_req, 1);
                chk("t5_addr", pre_addr, i < 2 ? 32'h204 : 32'h300);
            end
        end
        tick(0, 1, 0, 0, 0, 0, 0);             chk("t5_accept_addr", pre_addr, 32'h300);
        tick(0, 0, 1, md(32'h300), 0, 0, 0);   chk("t5_valid", valid_if, 1); chk("t5_pc", pc_if, 32'h300);

        // top-of-memory reset PC, wrap, and reset while a buffered instruction waits
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("t6_rst_valid", valid2, 0); chk("t6_rst_pc", pc2, 0); chk("t6_rst_instr", instr2, NOP);
        reset2 = 0; imem2.req_ready = 1;
        tick(0, 0, 0, 0, 0, 0, 0);             chk("t6_first_addr", pre_addr2, 32'hFFFF_FFFC); chk("t6_first_req", pre_req2, 1);
        imem2.req_ready = 0; imem2.rsp_valid = 1; imem2.rsp_data = md(32'hFFFF_FFFC);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("t6_valid", valid2, 1); chk("t6_pc", pc2, 32'hFFFF_FFFC); chk("t6_pc4_wrap", pc42, 0);
        imem2.rsp_valid = 0; imem2.req_ready = 1;
        tick(0, 0, 0, 0, 0, 0, 0);             chk("t6_wrap_addr", pre_addr2, 0);
        imem2.req_ready = 0; imem2.rsp_valid = 1; imem2.rsp_data = md(0);
        tick(0, 0, 0, 0, 1, 0, 0);             chk("t6_full_hold", pc2, 32'hFFFF_FFFC);
        imem2.rsp_valid = 0; reset2 = 1;
        tick(0, 0, 0, 0, 1, 0, 0);
        chk("t6_reset_valid", valid2, 0); chk("t6_reset_pc", pc2, 0); chk("t6_reset_pc4", pc42, 0); chk("t6_reset_instr", instr2, NOP);
        reset2 = 0; imem2.req_ready = 1;
        tick(0, 0, 0, 0, 0, 0, 0);             chk("t6_restart_req", pre_req2, 1); chk("t6_restart_addr", pre_addr2, 32'hFFFF_FFFC);
        reset2 = 1; imem2.req_ready = 0;

        // randomized run: the delivered stream must be sequential from the last redirect/reset
        begin
            logic        hp, busy;
            logic [31:0] ha, maddr, exp_pc;
            int          lat, delivered;
            hp = 0; busy = 0; ha = 0; maddr = 0; exp_pc = 0; lat = 0; delivered = 0;
            for (int c = 0; c < 4000; c++) begin
                logic        r, rd, rs, st, rv, o_v;
                logic [31:0] rp, o_ins, o_pc, o_p4;
                r  = c == 0 || $urandom_range(0, 299) == 0;
                rd = $urandom_range(0, 2) != 0;
                rs = busy && lat == 0;
                st = $urandom_range(0, 3) == 0;
                rv = $urandom_range(0, 11) == 0;
                rp = $urandom;
                o_ins = instr_if; o_pc = pc_if; o_p4 = pc_plus4_if; o_v = valid_if;
                tick(r, rd, rs, md(maddr), st, rv, rp);
                if (!r && rv) chk("rnd_req_low_on_redirect", pre_req, 0);
                else if (!r && hp) begin
                    chk("rnd_req_held", pre_req, 1);
                    chk("rnd_addr_held", pre_addr, ha);
                end
                hp = !r && pre_req && !rd;
                ha = pre_addr;
                if (r) busy = 0;
                else begin
                    if (rs) busy = 0;
                    else if (busy && lat > 0) lat--;
                    if (pre_req && rd) begin
                        chk("rnd_one_outstanding", busy, 0);
                        busy = 1; maddr = pre_addr; lat = $urandom_range(0, 3);
                    end
                end
                if (r) begin
                    chk("rnd_reset_valid", valid_if, 0); chk("rnd_reset_pc", pc_if, 0);
                    chk("rnd_reset_pc4", pc_plus4_if, 0); chk("rnd_reset_instr", instr_if, NOP);
                    exp_pc = 0;
                end else if (rv) begin
                    chk("rnd_flush_valid", valid_if, 0); chk("rnd_flush_instr", instr_if, NOP);
                    chk("rnd_flush_pc_hold", pc_if, o_pc);
                    exp_pc = {rp[31:2], 2'b00};
                end else if (st) begin
                    chk("rnd_stall_valid", valid_if, o_v); chk("rnd_stall_instr", instr_if, o_ins);
                    chk("rnd_stall_pc", pc_if, o_pc); chk("rnd_stall_pc4", pc_plus4_if, o_p4);
                end else if (valid_if) begin
                    chk("rnd_pc", pc_if, exp_pc); chk("rnd_instr", instr_if, md(exp_pc));
                    chk("rnd_pc4", pc_plus4_if, exp_pc + 32'd4);
                    exp_pc += 32'd4;
                    delivered++;
                end else begin
                    chk("rnd_bubble_instr", instr_if, NOP); chk("rnd_bubble_pc_hold", pc_if, o_pc);
                end
            end
            chk("rnd_progress", delivered > 100, 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
